matriz_loader_5x5: RTL and testbench

- Upstream stage of the 5x5 determinant block.
- Accepts signed 8-bit elements one per handshake, in row-major order (a00, a01 … a44).
- Assembles them into the 200-bit packed matrix bus consumed by the determinant block.
- Presents the completed matrix with a valid/ready handshake and holds it stable until it is taken.

---
 rtl/matriz_pkg.sv | 25 ++
 rtl/matriz_idx_counter.sv | 64 ++++++
 rtl/matriz_loader_5x5.sv | 155 +++++++++++++++
 tb/tb_matriz_loader_5x5.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// matriz_pkg: constants, FSM state type and bus offset helper shared by the
// 5x5 matrix loader and the determinant block that consumes its bus.
package matriz_pkg;

    localparam int N      = 5;
    localparam int DATA_W = 8;
    localparam int ROW_W  = N * DATA_W;     // 40 bits per matrix row
    localparam int MAT_W  = N * ROW_W;      // 200-bit packed matrix
    localparam int IDX_W  = 3;              // row/col index width
    localparam int CNT_W  = 5;              // element count width (0..25)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Bit offset of element [i][j] inside the packed bus: i*40 + j*8.
    // Highest offset is 192, so 8 bits are enough for the arithmetic.
    function automatic logic [7:0] bit_off(input logic [IDX_W-1:0] i,
                                           input logic [IDX_W-1:0] j);
        return ({5'd0, i} * 8'(ROW_W)) + ({5'd0, j} * 8'(DATA_W));
    endfunction

endpackage

// File: rtl/matriz_idx_counter.sv
// matriz_idx_counter: row-major row/col walker for the 5x5 loader.
// Tracks the slot the next element lands in plus the running element count,
// and flags the terminal (25th) slot so the loader can close the matrix.
module matriz_idx_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,     // synchronous return to slot [0][0]
    input  logic       inc_i,     // one element accepted this cycle
    output logic [2:0] row_o,
    output logic [2:0] col_o,
    output logic [4:0] count_o,
    output logic       last_o     // current slot is [4][4]
);
    import matriz_pkg::*;

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last_o  = (cnt_q == CNT_W'(N * N - 1));
    assign row_o   = row_q;
    assign col_o   = col_q;
    assign count_o = cnt_q;

    // Next slot: clear wins, completion wraps to [0][0], else step row-major.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
            cnt_d = '0;
        end else if (inc_i) begin
            if (last_o) begin
                row_d = '0;
                col_d = '0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (col_q == IDX_W'(N - 1)) begin
                    col_d = '0;
                    row_d = row_q + IDX_W'(1);
                end else begin
                    col_d = col_q + IDX_W'(1);
                end
            end
        end
    end

    // Index/count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            cnt_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matriz_loader_5x5.sv
// matriz_loader_5x5: collects 25 signed 8-bit elements (row-major, one per
// valid/ready handshake) into a 200-bit packed matrix and holds it on a
// valid/ready output until taken. in_last position mismatches pulse
// frame_err; an early in_last discards the partial matrix.
// Optional feature macro MATRIZ_ZERO_ROW_EN adds zero_row, flagging a held
// matrix that contains an all-zero row (determinant known to be 0).
module matriz_loader_5x5 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [199:0] matriz_5x5,
    output logic         frame_err,
    output logic [4:0]   elem_count
`ifdef MATRIZ_ZERO_ROW_EN
    ,
    output logic         zero_row
`endif
);
    import matriz_pkg::*;

    state_e           state_q, state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             ferr_q, ferr_d;
    logic [MAT_W-1:0] mat_q, mat_d;

    logic             accept;
    logic             early_last;
    logic [IDX_W-1:0] row, col;
    logic [CNT_W-1:0] cnt;
    logic             term;
    logic [7:0]       off;

    // clear blocks acceptance so it takes priority over a concurrent handshake.
    assign accept     = in_valid && in_ready_q && !clear;
    assign early_last = accept && in_last && !term;
    assign off        = bit_off(row, col);

    matriz_idx_counter u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clear || early_last),
        .inc_i   (accept),
        .row_o   (row),
        .col_o   (col),
        .count_o (cnt),
        .last_o  (term)
    );

    // Next state and frame error: completion on the 25th element, abort on
    // an early in_last, release from HOLD on the output handshake.
    always_comb begin
        state_d = state_q;
        ferr_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (term) begin
                            state_d = HOLD;
                            ferr_d  = !in_last;
                        end else if (in_last) begin
                            state_d = IDLE;
                            ferr_d  = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Matrix bus: write the accepted element into its slot; clear zeroes it.
    always_comb begin
        mat_d = mat_q;
        if (clear) begin
            mat_d = '0;
        end else if (accept) begin
            mat_d[off +: DATA_W] = in_data;
        end
    end

    // State, handshake flags, frame error and matrix registers. The flags are
    // registered from state_d so both read 0 while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ferr_q      <= 1'b0;
            mat_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != HOLD);
            out_valid_q <= (state_d == HOLD);
            ferr_q      <= ferr_d;
            mat_q       <= mat_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign frame_err  = ferr_q;
    assign matriz_5x5 = mat_q;
    assign elem_count = cnt;

`ifdef MATRIZ_ZERO_ROW_EN
    logic [N-1:0] rz_q, rz_d;   // per-row "all zero so far"
    logic         zr_q, zr_d;
    logic         byte_zero;

    assign byte_zero = (in_data == '0);

    // Row zero tracking: column 0 restarts a row, later columns AND in; the
    // flag is latched when the matrix completes so it is valid with out_valid.
    always_comb begin
        rz_d = rz_q;
        zr_d = zr_q;
        if (clear) begin
            rz_d = '0;
            zr_d = 1'b0;
        end else if (accept) begin
            rz_d[row] = (col == '0) ? byte_zero : (rz_q[row] && byte_zero);
            if (term) zr_d = |rz_d;
        end
    end

    // Zero-row registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rz_q <= '0;
            zr_q <= 1'b0;
        end else begin
            rz_q <= rz_d;
            zr_q <= zr_d;
        end
    end

    assign zero_row = zr_q;
`endif

endmodule

// File: tb/tb_matriz_loader_5x5.sv
// Self-checking bench for matriz_loader_5x5: table-driven directed matrices,
// hand-written reset/clear sequences and a randomized phase, all checked
// every cycle against a queue-based reference model.
module tb_matriz_loader_5x5;

    logic         clk, rst_n, clear, in_valid, in_ready, in_last;
    logic [7:0]   in_data;
    logic         out_valid, out_ready, frame_err;
    logic [199:0] matriz_5x5;
    logic [4:0]   elem_count;
`ifdef MATRIZ_ZERO_ROW_EN
    logic         zero_row;
`endif

    matriz_loader_5x5 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .matriz_5x5 (matriz_5x5),
        .frame_err  (frame_err),
        .elem_count (elem_count)
`ifdef MATRIZ_ZERO_ROW_EN
        ,
        .zero_row   (zero_row)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [7:0] mq[$];          // elements of the matrix being assembled
    logic [7:0] m_el[25];       // last value written to each slot
    logic       m_hold, m_rdy, m_ferr, m_zr;

    function automatic logic [199:0] m_bus();
        logic [199:0] b = '0;
        for (int k = 0; k < 25; k++) b = b | (200'(m_el[k]) << (8 * k));
        return b;
    endfunction

    function automatic logic any_zero_row();
        logic r = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic z = 1'b1;
            for (int j = 0; j < 5; j++) if (m_el[i*5+j] != 8'h00) z = 1'b0;
            if (z) r = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < 25; k++) m_el[k] = 8'h00;
        m_hold = 0; m_rdy = 0; m_ferr = 0; m_zr = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_tick();
        if (clear) begin
            mq.delete();
            for (int k = 0; k < 25; k++) m_el[k] = 8'h00;
            m_hold = 0; m_ferr = 0; m_zr = 0;
        end else begin
            m_ferr = 0;
            if (m_hold && out_ready) begin
                m_hold = 0;
            end else if (in_valid && m_rdy) begin
                m_el[mq.size()] = in_data;
                mq.push_back(in_data);
                if (mq.size() == 25) begin
                    m_hold = 1;
                    m_ferr = !in_last;
                    m_zr   = any_zero_row();
                    mq.delete();
                end else if (in_last) begin
                    m_ferr = 1;
                    mq.delete();
                end
            end
        end
        m_rdy = !m_hold;
    endtask

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready",   200'(in_ready),   200'(m_rdy));
        chk("out_valid",  200'(out_valid),  200'(m_hold));
        chk("frame_err",  200'(frame_err),  200'(m_ferr));
        chk("elem_count", 200'(elem_count), 200'(mq.size()));
        chk("matriz",     matriz_5x5,       m_bus());
`ifdef MATRIZ_ZERO_ROW_EN
        if (m_hold) chk("zero_row", 200'(zero_row), 200'(m_zr));
`endif
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] elem(input int kind, input int k);
        case (kind)
            0:       return (k % 6 == 0) ? 8'd1 : 8'd0;        // identity
            1:       return 8'(-(k + 1));                      // -1 .. -25
            3:       return (k / 5 == 2) ? 8'd0 : 8'(k + 1);   // row 2 zero
            default: return 8'(k + 1);                         // 1 .. 25
        endcase
    endfunction

    task automatic feed(input int kind, input int n, input int last_at);
        for (int k = 0; k < n; k++) begin
            in_valid = 1; in_data = elem(kind, k); in_last = (k == last_at);
            step();
        end
        in_valid = 0; in_last = 0; in_data = 8'h00;
    endtask

    typedef struct {
        int         kind;
        int         last_at;   // index carrying in_last, -1 for none
        int         hold_cyc;  // cycles out_ready stays low before taking
        logic       done;      // matrix expected to complete
        logic       ferr;      // frame_err expected after the last element
        logic [7:0] b0, b6, b24;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{kind:0, last_at:24, hold_cyc:2,  done:1, ferr:0, b0:8'h01, b6:8'h01, b24:8'h01};
        vt[1] = '{kind:1, last_at:24, hold_cyc:10, done:1, ferr:0, b0:8'hFF, b6:8'hF9, b24:8'hE7};
        vt[2] = '{kind:2, last_at:6,  hold_cyc:0,  done:0, ferr:1, b0:8'h00, b6:8'h00, b24:8'h00};
        vt[3] = '{kind:2, last_at:-1, hold_cyc:1,  done:1, ferr:1, b0:8'h01, b6:8'h07, b24:8'h19};
        vt[4] = '{kind:3, last_at:24, hold_cyc:1,  done:1, ferr:0, b0:8'h01, b6:8'h07, b24:8'h19};

        rst_n = 1; clear = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        model_reset();
        #1 rst_n = 0;
        #1;
        check_all();
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        step();

        // ---- table-driven directed matrices ----
        for (int v = 0; v < 5; v++) begin
            int n;
            n = (vt[v].last_at >= 0 && vt[v].last_at < 24) ? vt[v].last_at + 1 : 25;
            feed(vt[v].kind, n, vt[v].last_at);
            chk($sformatf("v%0d out_valid", v), 200'(out_valid), 200'(vt[v].done));
            chk($sformatf("v%0d frame_err", v), 200'(frame_err), 200'(vt[v].ferr));
            chk($sformatf("v%0d elem_count", v), 200'(elem_count), 200'(0));
            if (vt[v].done) begin
                chk($sformatf("v%0d byte0", v),  200'(matriz_5x5[7:0]),     200'(vt[v].b0));
                chk($sformatf("v%0d byte6", v),  200'(matriz_5x5[55:48]),   200'(vt[v].b6));
                chk($sformatf("v%0d byte24", v), 200'(matriz_5x5[199:192]), 200'(vt[v].b24));
`ifdef MATRIZ_ZERO_ROW_EN
                chk($sformatf("v%0d zero_row", v), 200'(zero_row), 200'(vt[v].kind == 3));
`endif
                // Held matrix must ignore offered elements while out_ready is low.
                in_valid = 1; in_data = 8'h55;
                for (int c = 0; c < vt[v].hold_cyc; c++) step();
                out_ready = 1;
                step();
                out_ready = 0; in_valid = 0;
                chk($sformatf("v%0d released", v), 200'({out_valid, in_ready}), 200'(2'b01));
            end
        end

        // ---- randomized phase ----
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 8'($urandom);
            in_last   = (mq.size() == 24) ? ($urandom_range(3) != 0) : ($urandom_range(49) == 0);
            out_ready = ($urandom_range(1) == 1);
            clear     = ($urandom_range(79) == 0);
            step();
        end
        in_valid = 0; in_last = 0; out_ready = 0; clear = 1;
        step();
        clear = 0;

        // ---- async reset in the middle of a load ----
        feed(2, 12, -1);
        chk("mid elem_count", 200'(elem_count), 200'(12));
        #1 rst_n = 0;
        #1;
        model_reset();
        chk("rst all zero", {matriz_5x5[194:0], elem_count},
            {matriz_5x5[194:0] & 195'd0, 5'd0});
        chk("rst flags", 200'({in_ready, out_valid, frame_err}), 200'(0));
        check_all();
        #2 rst_n = 1;
        step();

        // ---- clear while holding a matrix ----
        feed(4, 25, 24);
        chk("pre-clear out_valid", 200'(out_valid), 200'(1));
        clear = 1; out_ready = 1; in_valid = 1;
        step();
        clear = 0; out_ready = 0; in_valid = 0;
        chk("clear out_valid", 200'(out_valid), 200'(0));
        chk("clear matriz", matriz_5x5, 200'(0));
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
